// File: rtl/seq_det_ctrl.sv
// Overlapping serial sequence detector with a programmable PAT_W-bit pattern and
// a window controller that counts matches and records the first match index.
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] first_idx,
  output logic             first_vld,
  output logic             overflow
);

  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_done_set;

  logic [PAT_W-1:0]   r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [PAT_W-2:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [LEN_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_first_idx;
  logic               r_first_vld;
  logic               r_ovf;
  logic               r_done;

  logic               w_not_run;
  logic               w_start;
  logic               w_cfg;
  logic [LEN_W-1:0]   w_eff_len;
  logic               w_consume;
  logic               w_last;
  logic [PAT_W-1:0]   w_window;
  logic               w_match;

  // A simultaneous cfg_we/start applies the new config to the window being started.
  assign w_not_run = (r_state != S_RUN);
  assign w_start   = start & w_not_run;
  assign w_cfg     = cfg_we & w_not_run;
  assign w_eff_len = w_cfg ? cfg_len : r_len;
  assign w_consume = (r_state == S_RUN) & din_valid & ~abort;
  assign w_window  = {r_hist, din};
  assign w_last    = (r_bit_idx == (r_len - LEN_W'(1)));
  assign w_match   = w_consume & (r_fill == FILL_MAX) & (w_window == r_pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (w_eff_len != '0) begin
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_DONE;
            w_done_set   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_consume && w_last) begin
          w_next_state = S_DONE;
          w_done_set   = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Window datapath: config, history, fill, index and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern   <= '0;
      r_len       <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_cfg) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
      end
      if (w_start) begin
        r_hist      <= '0;
        r_fill      <= '0;
        r_bit_idx   <= '0;
        r_cnt       <= '0;
        r_first_idx <= '0;
        r_first_vld <= 1'b0;
        r_ovf       <= 1'b0;
      end else if (w_consume) begin
        r_hist    <= w_window[PAT_W-2:0];
        r_bit_idx <= r_bit_idx + LEN_W'(1);
        if (r_fill < FILL_MAX) r_fill <= r_fill + FILL_W'(1);
        if (w_match) begin
          if (&r_cnt) r_ovf <= 1'b1;
          else        r_cnt <= r_cnt + CNT_W'(1);
          if (!r_first_vld) begin
            r_first_idx <= r_bit_idx;
            r_first_vld <= 1'b1;
          end
        end
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign match     = w_match;
  assign match_cnt = r_cnt;
  assign first_idx = r_first_idx;
  assign first_vld = r_first_vld;
  assign overflow  = r_ovf;

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable-pattern, overlapping serial sequence detector with a run controller.
- Software loads a PAT_W-bit pattern and a window length, then pulses start. The block consumes exactly cfg_len valid input bits and produces:
  - a Mealy match strobe,
  - a saturating match count,
  - the index of the first match.
- Sits between the serial bit source and the status/interrupt logic. It replaces fixed-pattern detectors wherever the pattern must change at run time.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- LEN_W, 8, width of window length and bit index.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  load cfg_pattern/cfg_len; honoured only in IDLE or DONE.
- cfg_pattern  in  PAT_W  pattern; MSB is the oldest bit.
- cfg_len  in  LEN_W  number of valid bits in the window.
- start  in  1  begin a window; honoured only in IDLE or DONE.
- abort  in  1  terminate the window immediately.
- din  in  1  serial data bit.
- din_valid  in  1  din qualifier; bits are consumed only when high.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the window completes.
- match  out  1  Mealy match strobe, combinational from din.
- match_cnt  out  CNT_W  matches in current/last window.
- first_idx  out  LEN_W  window bit index (0-based) of the last bit of the first match.
- first_vld  out  1  first_idx is valid.
- overflow  out  1  sticky; match_cnt saturated this window.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - pattern=0, len=0, history=0, fill=0, bit_idx=0.
  - All outputs 0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on start when cfg_len!=0.
  - IDLE/DONE -> DONE on start when cfg_len==0, with done pulsed and results cleared.
  - RUN -> DONE on the consumed bit where bit_idx==len-1; done pulses on the following cycle.
  - RUN -> IDLE on abort.
  - DONE is a resting state; results hold until the next start.
- On start:
  - Clear history, fill, bit_idx, match_cnt, first_vld, first_idx and overflow.
  - The first bit is consumed on the cycle after start.
- Config:
  - cfg_we registers pattern and len on the edge.
  - Ignored in RUN.
  - If cfg_we and start arrive in the same cycle from IDLE/DONE, the new config is used for that window.
- Detection (overlapping):
  - match = (state==RUN) & din_valid & (fill>=PAT_W-1) & ({history[PAT_W-2:0],din}==pattern).
  - The history shift register shifts in din on every consumed bit.
  - fill saturates at PAT_W-1.
  - Matches never span windows.
- Per consumed bit:
  - bit_idx increments.
  - On match, match_cnt increments. At all-ones it holds and overflow sets.
  - On the first match, first_idx=bit_idx and first_vld=1.
- din_valid=0 in RUN: nothing changes and match=0. Stalls of any length are allowed.
- abort:
  - Takes priority over the bit consumed in the same cycle; that bit is not counted and match is forced to 0.
  - No done pulse is generated; results hold.
- start or cfg_we in RUN: ignored.
- Simultaneous start and abort in IDLE/DONE: start wins.
- rst mid-window: everything returns to reset values asynchronously.

Test Plan:
- Pattern 1011, len 7, stream 1,0,1,1,0,1,1 with din_valid always 1 -> match on idx 3 and 6; match_cnt=2; first_idx=3; first_vld=1; done 1 cycle after idx 6; busy falls with done.
- Pattern 1111, len 6, stream all ones -> matches at idx 3,4,5 (overlap); match_cnt=3.
- Same as the first case with din_valid low for 3 cycles between each bit -> identical match_cnt=2 and first_idx=3; match never high while din_valid=0.
- CNT_W=2, pattern 11, len 8, all ones -> matches at idx 1..7; match_cnt saturates at 3; overflow=1.
- Abort asserted on idx 4 of the first stream -> returns to IDLE; no done; match_cnt=1; then cfg_we with len=0 plus start -> done pulse, match_cnt=0, first_vld=0.
- rst asserted mid-window; cfg_we and start asserted in RUN -> all outputs 0 immediately after rst; cfg_we and start in RUN are ignored (pattern, len and counters unchanged).
